// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the nibble-serial ALU sequencer.
//   NIBBLE_W        width of one ALU slice (4 bits)
//   OP_ADD..OP_SHL  3-bit function codes understood by alu_slice4
//   state_t         FSM state type with ST_IDLE / ST_RUN / ST_DONE encodings
package alu_seq_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_AND   = 3'd1;
  localparam logic [2:0] OP_OR    = 3'd2;
  localparam logic [2:0] OP_XOR   = 3'd3;
  localparam logic [2:0] OP_PASSA = 3'd4;
  localparam logic [2:0] OP_PASSB = 3'd5;
  localparam logic [2:0] OP_SHR   = 3'd6;
  localparam logic [2:0] OP_SHL   = 3'd7;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/alu_slice4.sv
// alu_slice4: combinational 4-bit ALU slice.
//   da_i, db_i      nibble operands
//   f_i             function code (OP_* from alu_seq_pkg)
//   ci_left_i       bit shifted in at the MSB for SHR
//   ci_right_i      carry-in for ADD, bit shifted in at the LSB for SHL
//   com_i           invert the output nibble (1's complement)
//   d_o             output nibble (after optional complement)
//   co_left_o       carry-out of ADD, bit shifted out of the MSB for SHL
//   co_right_o      bit shifted out of the LSB for SHR
//   zero_o          d_o is all zeros
//   neg_zero_o      d_o is all ones
//   equ_o           da_i equals db_i
module alu_slice4
  import alu_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] da_i,
  input  logic [NIBBLE_W-1:0] db_i,
  input  logic [2:0]          f_i,
  input  logic                ci_left_i,
  input  logic                ci_right_i,
  input  logic                com_i,
  output logic [NIBBLE_W-1:0] d_o,
  output logic                co_left_o,
  output logic                co_right_o,
  output logic                zero_o,
  output logic                neg_zero_o,
  output logic                equ_o
);

  logic [NIBBLE_W-1:0] raw;

  // NOTE: every output of a combinational block gets a default before the
  // case so that no path leaves it unassigned, which would infer a latch.
  always_comb begin
    raw        = '0;
    co_left_o  = 1'b0;
    co_right_o = 1'b0;
    case (f_i)
      OP_ADD:   {co_left_o, raw} = {1'b0, da_i} + {1'b0, db_i} + {{NIBBLE_W{1'b0}}, ci_right_i};
      OP_AND:   raw = da_i & db_i;
      OP_OR:    raw = da_i | db_i;
      OP_XOR:   raw = da_i ^ db_i;
      OP_PASSA: raw = da_i;
      OP_PASSB: raw = db_i;
      OP_SHR: begin
        raw        = {ci_left_i, da_i[NIBBLE_W-1:1]};
        co_right_o = da_i[0];
      end
      OP_SHL: begin
        raw       = {da_i[NIBBLE_W-2:0], ci_right_i};
        co_left_o = da_i[NIBBLE_W-1];
      end
      default: raw = '0;
    endcase
  end

  // Complement applies to the data only; carries keep their true sense.
  assign d_o        = com_i ? ~raw : raw;
  assign zero_o     = (d_o == '0);
  assign neg_zero_o = (d_o == '1);
  assign equ_o      = (da_i == db_i);

endmodule

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: runs a 4*NIBBLES-bit operation through one shared
// 4-bit ALU slice, one nibble per clock.
//   clk, rst_n      clock, synchronous active-low reset
//   start_i         request, sampled only when idle
//   op_i, com_i     function code and output-complement mode
//   cin_i           wide carry / shift-in
//   acc_sel_i       use result register as A operand (ALU_SEQ_ACCUM_EN builds)
//   a_i, b_i        wide operands
//   busy_o, done_o  operation in progress, one-cycle completion pulse
//   result_o        assembled result register
//   cout_o          wide carry / shift-out
//   zero_o, neg_zero_o, equ_o  result all-0, result all-1, A==B
// Build option: define ALU_SEQ_ACCUM_EN to honour acc_sel_i; otherwise the
// port is present but ignored.
module alu_nibble_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic [2:0]                  op_i,
  input  logic                        com_i,
  input  logic                        cin_i,
  input  logic                        acc_sel_i,
  input  logic [NIBBLE_W*NIBBLES-1:0] a_i,
  input  logic [NIBBLE_W*NIBBLES-1:0] b_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [NIBBLE_W*NIBBLES-1:0] result_o,
  output logic                        cout_o,
  output logic                        zero_o,
  output logic                        neg_zero_o,
  output logic                        equ_o
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int CNT_W = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2:0]       op_q, op_d;
  logic             com_q, com_d, link_q, link_d;
  logic             zero_q, zero_d, negz_q, negz_d, equ_q, equ_d;

  // SHR walks MSB first so the shifted bit moves downward through `link`.
  logic [CNT_W-1:0]    nib_sel;
  logic [NIBBLE_W-1:0] s_d;
  logic                s_co_left, s_co_right, s_zero, s_negz, s_equ;

  assign nib_sel = (op_q == OP_SHR) ? (LAST - cnt_q) : cnt_q;

  alu_slice4 u_slice (
    .da_i       (a_q[nib_sel*NIBBLE_W +: NIBBLE_W]),
    .db_i       (b_q[nib_sel*NIBBLE_W +: NIBBLE_W]),
    .f_i        (op_q),
    .ci_left_i  (link_q),
    .ci_right_i (link_q),
    .com_i      (com_q),
    .d_o        (s_d),
    .co_left_o  (s_co_left),
    .co_right_o (s_co_right),
    .zero_o     (s_zero),
    .neg_zero_o (s_negz),
    .equ_o      (s_equ)
  );

`ifndef ALU_SEQ_ACCUM_EN
  logic acc_sel_unused;
  assign acc_sel_unused = acc_sel_i;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    com_d    = com_q;
    link_d   = link_q;
    result_d = result_q;
    zero_d   = zero_q;
    negz_d   = negz_q;
    equ_d    = equ_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
`ifdef ALU_SEQ_ACCUM_EN
          a_d = acc_sel_i ? result_q : a_i;
`else
          a_d = a_i;
`endif
          b_d      = b_i;
          op_d     = op_i;
          com_d    = com_i;
          link_d   = cin_i;
          cnt_d    = '0;
          result_d = '0;
          zero_d   = 1'b1;
          negz_d   = 1'b1;
          equ_d    = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        result_d[nib_sel*NIBBLE_W +: NIBBLE_W] = s_d;
        case (op_q)
          OP_ADD, OP_SHL: link_d = s_co_left;
          OP_SHR:         link_d = s_co_right;
          default:        link_d = 1'b0;
        endcase
        zero_d = zero_q & s_zero;
        negz_d = negz_q & s_negz;
        equ_d  = equ_q & s_equ;
        if (cnt_q == LAST) state_d = ST_DONE;
        else               cnt_d   = cnt_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      com_q    <= 1'b0;
      link_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      negz_q   <= 1'b0;
      equ_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      com_q    <= com_d;
      link_q   <= link_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      negz_q   <= negz_d;
      equ_q    <= equ_d;
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = (state_q == ST_DONE);
  assign result_o   = result_q;
  assign cout_o     = link_q;
  assign zero_o     = zero_q;
  assign neg_zero_o = negz_q;
  assign equ_o      = equ_q;

endmodule
